// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: walks a 4-input function under test through all 16 input
// vectors, records its output into a captured truth table and compares the
// result against a reference truth table latched at start.
// Optional feature macro: TT_SWEEP_ERRCNT_EN adds the err_cnt mismatch counter.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected_tt,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  input  logic        y0,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
`ifdef TT_SWEEP_ERRCNT_EN
  output logic [4:0]  err_cnt,
`endif
  output logic [3:0]  first_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // Last settle count value before moving on to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] exp_reg, exp_next;
  logic [15:0] tt_reg, tt_next;
  logic [3:0]  x_reg, x_next;
  logic        match_reg, match_next;
  logic [3:0]  first_err_reg, first_err_next;
  logic        err_seen_reg, err_seen_next;
  logic        mismatch;
`ifdef TT_SWEEP_ERRCNT_EN
  logic [4:0]  err_cnt_reg, err_cnt_next;
`endif

  // Current sample disagrees with the captured reference bit.
  assign mismatch = (y0 != exp_reg[idx_reg]);

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 4'd0;
      cnt_reg       <= 4'd0;
      exp_reg       <= 16'd0;
      tt_reg        <= 16'd0;
      x_reg         <= 4'd0;
      match_reg     <= 1'b0;
      first_err_reg <= 4'd0;
      err_seen_reg  <= 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
      err_cnt_reg   <= 5'd0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      exp_reg       <= exp_next;
      tt_reg        <= tt_next;
      x_reg         <= x_next;
      match_reg     <= match_next;
      first_err_reg <= first_err_next;
      err_seen_reg  <= err_seen_next;
`ifdef TT_SWEEP_ERRCNT_EN
      err_cnt_reg   <= err_cnt_next;
`endif
    end
  end

  // Next-state and datapath updates; x is computed one cycle ahead so the
  // drive lines come straight from a register.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    exp_next       = exp_reg;
    tt_next        = tt_reg;
    x_next         = x_reg;
    match_next     = match_reg;
    first_err_next = first_err_reg;
    err_seen_next  = err_seen_reg;
`ifdef TT_SWEEP_ERRCNT_EN
    err_cnt_next   = err_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          exp_next       = expected_tt;
          tt_next        = 16'd0;
          match_next     = 1'b0;
          first_err_next = 4'd0;
          err_seen_next  = 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
          err_cnt_next   = 5'd0;
`endif
          idx_next       = 4'd0;
          cnt_next       = 4'd0;
          x_next         = 4'd0;
          state_next     = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_next = IDLE;
          idx_next   = 4'd0;
          cnt_next   = 4'd0;
          x_next     = 4'd0;
          match_next = 1'b0;
        end else if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = 4'd0;
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          // Abort beats completion, even on the last vector.
          state_next = IDLE;
          idx_next   = 4'd0;
          cnt_next   = 4'd0;
          x_next     = 4'd0;
          match_next = 1'b0;
        end else begin
          tt_next[idx_reg] = y0;
          if (mismatch) begin
            if (!err_seen_reg) begin
              first_err_next = idx_reg;
            end
            err_seen_next = 1'b1;
`ifdef TT_SWEEP_ERRCNT_EN
            err_cnt_next  = err_cnt_reg + 5'd1;
`endif
          end
          if (idx_reg == 4'd15) begin
            state_next = DONE;
            idx_next   = 4'd0;
            x_next     = 4'd0;
            match_next = !(err_seen_reg || mismatch);
          end else begin
            idx_next   = idx_reg + 4'd1;
            x_next     = idx_reg + 4'd1;
            state_next = DRIVE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign x0        = x_reg[0];
  assign x1        = x_reg[1];
  assign x2        = x_reg[2];
  assign x3        = x_reg[3];
  assign busy      = (state_reg == DRIVE) || (state_reg == SAMPLE);
  assign done      = (state_reg == DONE);
  assign tt        = tt_reg;
  assign match     = match_reg;
  assign first_err = first_err_reg;
`ifdef TT_SWEEP_ERRCNT_EN
  assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: instance A (SETTLE=1) takes directed and random
// sweeps, restarts, aborts and reset; instance B (SETTLE=3) checks the
// slower drive sequence. Honours TT_SWEEP_ERRCNT_EN when defined.
module tb_tt_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A, SETTLE=1; its function under test is a lookup into a_func.
  logic        a_start = 1'b0, a_abort = 1'b0;
  logic [15:0] a_exp = 16'd0, a_func = 16'd0;
  logic        a_x0, a_x1, a_x2, a_x3, a_y, a_busy, a_done, a_match;
  logic [15:0] a_tt;
  logic [3:0]  a_ferr, a_x;
  logic [4:0]  a_ecnt;
  assign a_x = {a_x3, a_x2, a_x1, a_x0};
  assign a_y = a_func[a_x];

  // Instance B, SETTLE=3; function under test is a 4-input AND.
  logic        b_start = 1'b0, b_abort = 1'b0;
  logic [15:0] b_exp = 16'd0;
  logic        b_x0, b_x1, b_x2, b_x3, b_y, b_busy, b_done, b_match;
  logic [15:0] b_tt;
  logic [3:0]  b_ferr, b_x;
  logic [4:0]  b_ecnt;
  assign b_x = {b_x3, b_x2, b_x1, b_x0};
  assign b_y = b_x0 & b_x1 & b_x2 & b_x3;

`ifndef TT_SWEEP_ERRCNT_EN
  assign a_ecnt = 5'd0;
  assign b_ecnt = 5'd0;
`endif

  tt_sweep_ctrl #(.SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .expected_tt(a_exp), .x0(a_x0), .x1(a_x1), .x2(a_x2), .x3(a_x3),
    .y0(a_y), .busy(a_busy), .done(a_done), .tt(a_tt), .match(a_match),
`ifdef TT_SWEEP_ERRCNT_EN
    .err_cnt(a_ecnt),
`endif
    .first_err(a_ferr)
  );

  tt_sweep_ctrl #(.SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .expected_tt(b_exp), .x0(b_x0), .x1(b_x1), .x2(b_x2), .x3(b_x3),
    .y0(b_y), .busy(b_busy), .done(b_done), .tt(b_tt), .match(b_match),
`ifdef TT_SWEEP_ERRCNT_EN
    .err_cnt(b_ecnt),
`endif
    .first_err(b_ferr)
  );

  // Reference: result of sweeping function f against reference e.
  task automatic model(input logic [15:0] f, input logic [15:0] e,
                       output logic m, output logic [3:0] fe, output logic [4:0] ec);
    bit found = 0;
    m  = (f == e);
    fe = 4'd0;
    ec = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (f[i] != e[i]) begin
        ec = ec + 5'd1;
        if (!found) fe = 4'(i);
        found = 1;
      end
    end
  endtask

  // Full sweep on A with optional second start, mid-sweep reference change,
  // and abort pulse in the DONE cycle. Cycle m is the cycle after edge E0+m.
  task automatic a_sweep(input logic [15:0] f, input logic [15:0] e,
                         input int restart_at, input int exp_change_at,
                         input bit abort_in_done, input string name);
    logic       m_e;
    logic [3:0] fe_e;
    logic [4:0] ec_e;
    int         done_cnt = 0;
    logic       busy_e, done_e;
    logic [3:0] x_e;
    model(f, e, m_e, fe_e, ec_e);
    a_func = f;
    @(negedge clk);
    a_exp   = e;
    a_start = 1'b1;
    @(negedge clk);
    for (int m = 0; m <= 33; m++) begin
      a_start = (m == restart_at);
      a_abort = abort_in_done && (m == 32);
      if (m == exp_change_at) a_exp = 16'hFFFF;
      busy_e = (m < 32);
      done_e = (m == 32);
      x_e    = (m < 32) ? 4'(m / 2) : 4'd0;
      if (a_done) done_cnt++;
      checks++;
      if ({a_busy, a_done, a_x} !== {busy_e, done_e, x_e}) begin
        errors++;
        $display("FAIL %s seq m=%0d: busy/done/x=%b/%b/%0d required %b/%b/%0d",
                 name, m, a_busy, a_done, a_x, busy_e, done_e, x_e);
      end
      @(negedge clk);
    end
    a_start = 1'b0;
    a_abort = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
    end
    checks++;
    if (a_tt !== f) begin
      errors++;
      $display("FAIL %s tt: got %h required %h", name, a_tt, f);
    end
    checks++;
    if (a_match !== m_e || a_ferr !== fe_e) begin
      errors++;
      $display("FAIL %s match/first_err: got %b/%0d required %b/%0d",
               name, a_match, a_ferr, m_e, fe_e);
    end
`ifdef TT_SWEEP_ERRCNT_EN
    checks++;
    if (a_ecnt !== ec_e) begin
      errors++;
      $display("FAIL %s err_cnt: got %0d required %0d", name, a_ecnt, ec_e);
    end
`endif
    $display("%s: f=%h exp=%h tt=%h match=%b first_err=%0d err_cnt=%0d",
             name, f, e, a_tt, a_match, a_ferr, a_ecnt);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_x, a_tt, a_match, a_ferr, a_ecnt} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b x=%h tt=%h match=%b ferr=%h ecnt=%h required all 0",
               a_busy, a_done, a_x, a_tt, a_match, a_ferr, a_ecnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset: outputs after async reset busy=%b done=%b tt=%h", a_busy, a_done, a_tt);
  endtask

  task automatic test_directed();
    a_sweep(16'h6996, 16'h6996, -1, -1, 0, "parity_exact");
    a_sweep(16'h6996, 16'h6997, -1, -1, 0, "parity_bit0");
    a_sweep(16'h6996, 16'h0000, -1, -1, 0, "parity_zero");
  endtask

  task automatic test_random();
    logic [15:0] f, e;
    for (int n = 0; n < 6; n++) begin
      f = 16'($urandom);
      case (n % 3)
        0: e = f;
        1: e = f ^ (16'd1 << $urandom_range(15, 0));
        default: e = 16'($urandom);
      endcase
      a_sweep(f, e, -1, -1, (n == 2), "random");
    end
  endtask

  task automatic test_back_to_back();
    a_sweep(16'h6996, 16'h6996, 10, 12, 0, "restart_ignored");
  endtask

  // Abort at cycle m of a sweep; checks idle outputs and no done afterwards.
  task automatic a_abort_at(input logic [15:0] f, input int abort_m, input string name);
    logic [15:0] part;
    int          done_cnt = 0;
    a_func = f;
    @(negedge clk);
    a_exp   = f;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int m = 0; m < abort_m; m++) @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    checks++;
    if ({a_busy, a_done, a_x, a_match} !== 7'd0) begin
      errors++;
      $display("FAIL %s idle_after_abort: busy=%b done=%b x=%0d match=%b required 0/0/0/0",
               name, a_busy, a_done, a_x, a_match);
    end
    if (abort_m % 2 == 0) begin
      part = f & 16'((32'd1 << (abort_m / 2)) - 32'd1);
      checks++;
      if (a_tt !== part) begin
        errors++;
        $display("FAIL %s partial_tt: got %h required %h", name, a_tt, part);
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (a_done || a_busy) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL %s no_done: saw %0d busy/done cycles required 0", name, done_cnt);
    end
    $display("%s: abort at m=%0d tt=%h match=%b", name, abort_m, a_tt, a_match);
  endtask

  task automatic test_abort();
    a_abort_at(16'h6996, 10, "abort_idx5");
    a_abort_at(16'h6996, 31, "abort_idx15_sample");
    // Abort in IDLE must not disturb held results of a finished sweep.
    a_sweep(16'hA5C3, 16'hA5C3, -1, -1, 0, "pre_idle_abort");
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_busy, a_tt, a_match, a_ferr} !== {1'b0, 16'hA5C3, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL idle_abort: busy=%b tt=%h match=%b ferr=%0d required 0/a5c3/1/0",
               a_busy, a_tt, a_match, a_ferr);
    end
    $display("idle_abort: tt=%h match=%b", a_tt, a_match);
  endtask

  task automatic test_reset_mid_sweep();
    a_func = 16'h6996;
    @(negedge clk);
    a_exp   = 16'h6996;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int m = 0; m < 20; m++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_x, a_tt, a_match, a_ferr, a_ecnt} !== 31'd0) begin
      errors++;
      $display("FAIL reset_mid_sweep: busy=%b x=%h tt=%h match=%b required all 0",
               a_busy, a_x, a_tt, a_match);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset_mid_sweep: outputs cleared tt=%h", a_tt);
    a_sweep(16'h6996, 16'h6996, -1, -1, 0, "after_reset");
  endtask

  task automatic test_settle3();
    logic       busy_e, done_e;
    logic [3:0] x_e;
    @(negedge clk);
    b_exp   = 16'h8000;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int m = 0; m <= 65; m++) begin
      busy_e = (m < 64);
      done_e = (m == 64);
      x_e    = (m < 64) ? 4'(m / 4) : 4'd0;
      checks++;
      if ({b_busy, b_done, b_x} !== {busy_e, done_e, x_e}) begin
        errors++;
        $display("FAIL settle3 seq m=%0d: busy/done/x=%b/%b/%0d required %b/%b/%0d",
                 m, b_busy, b_done, b_x, busy_e, done_e, x_e);
      end
      @(negedge clk);
    end
    checks++;
    if ({b_tt, b_match, b_ferr, b_ecnt} !== {16'h8000, 1'b1, 4'd0, 5'd0}) begin
      errors++;
      $display("FAIL settle3 result: tt=%h match=%b ferr=%0d ecnt=%0d required 8000/1/0/0",
               b_tt, b_match, b_ferr, b_ecnt);
    end
    $display("settle3: tt=%h match=%b", b_tt, b_match);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid_sweep();
    test_settle3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
